// File: rtl/t08_lcd_bus_writer_if.sv
// t08_lcd_bus_writer_if: upstream word handshake and 8080 write-bus signals of the LCD writer
interface t08_lcd_bus_writer_if #(
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_dc;
  logic [7:0]             in_data;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]             spi_outputs;
  logic                   spi_wrx;
  logic                   spi_rdx;
  logic                   spi_csx;
  logic                   spi_dcx;
  modport master (
    output in_valid, in_dc, in_data,
    input  in_ready, busy, fifo_count, spi_outputs, spi_wrx, spi_rdx, spi_csx, spi_dcx
  );
  modport slave (
    input  in_valid, in_dc, in_data,
    output in_ready, busy, fifo_count, spi_outputs, spi_wrx, spi_rdx, spi_csx, spi_dcx
  );
endinterface

// File: rtl/t08_lcd_bus_writer.sv
// t08_lcd_bus_writer: FIFO-buffered 8080 parallel-bus write engine with programmable strobe timing
module t08_lcd_bus_writer #(
  parameter int DEPTH   = 4,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input logic                 clk,
  input logic                 nRst,
  t08_lcd_bus_writer_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int CW  = $clog2(WR_LOW > WR_HIGH ? WR_LOW : WR_HIGH) + 1;
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, WR_LO = 2'd2, WR_HI = 2'd3;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          full, empty, push, pop, last;
  logic [7:0]    data_q;
  logic          dcx_q, wrx_q, csx_q;
  assign full  = count == CNW'(DEPTH);
  assign empty = count == '0;
  assign push  = bus.in_valid && !full;
  assign last  = cnt == '0;
  assign pop   = !empty && (state == IDLE || (state == WR_HI && last));
  assign bus.in_ready    = !full;
  assign bus.busy        = !empty || state != IDLE;
  assign bus.fifo_count  = count;
  assign bus.spi_outputs = data_q;
  assign bus.spi_dcx     = dcx_q;
  assign bus.spi_wrx     = wrx_q;
  assign bus.spi_csx     = csx_q;
  assign bus.spi_rdx     = 1'b1;
  // next state and phase down-counter; a burst chains WR_HI straight into SETUP
  always_comb begin
    state_nx = state == IDLE  ? (empty ? IDLE : SETUP)
             : state == SETUP ? WR_LO
             : state == WR_LO ? (last ? WR_HI : WR_LO)
             : last ? (empty ? IDLE : SETUP) : WR_HI;
    cnt_nx = state == SETUP            ? CW'(WR_LOW - 1)
           : (state == WR_LO && last) ? CW'(WR_HIGH - 1)
           : last ? cnt : cnt - CW'(1);
  end
  // FSM, FIFO bookkeeping and bus outputs registered from the next state
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= 8'h00;
      dcx_q  <= 1'b1;
      wrx_q  <= 1'b1;
      csx_q  <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CNW'(push) - CNW'(pop);
      wrx_q  <= state_nx != WR_LO;
      csx_q  <= state_nx == IDLE;
      if (pop) {dcx_q, data_q} <= mem[rd_ptr];
    end
  end
  // FIFO storage; stale entries are unreachable once the pointers reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.in_dc, bus.in_data};
endmodule

// File: tb/tb_t08_lcd_bus_writer.sv
// tb_t08_lcd_bus_writer: scoreboard bench for the LCD bus writer, default and WR_LOW=1/WR_HIGH=3 timing
module tb_t08_lcd_bus_writer;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  localparam int WRL [2] = '{2, 1};
  t08_lcd_bus_writer_if #(.DEPTH(4)) ia ();
  t08_lcd_bus_writer_if #(.DEPTH(4)) ib ();
  t08_lcd_bus_writer #(.DEPTH(4), .WR_LOW(2), .WR_HIGH(2)) dut_a (.clk(clk), .nRst(nRst), .bus(ia));
  t08_lcd_bus_writer #(.DEPTH(4), .WR_LOW(1), .WR_HIGH(3)) dut_b (.clk(clk), .nRst(nRst), .bus(ib));
  assign ib.in_valid = ia.in_valid;
  assign ib.in_dc    = ia.in_dc;
  assign ib.in_data  = ia.in_data;
  always #5 clk = ~clk;
  logic [1:0] wrx_s, csx_s, rdx_s;
  logic [8:0] word_s [2];
  assign wrx_s = {ib.spi_wrx, ia.spi_wrx};
  assign csx_s = {ib.spi_csx, ia.spi_csx};
  assign rdx_s = {ib.spi_rdx, ia.spi_rdx};
  assign word_s[0] = {ia.spi_dcx, ia.spi_outputs};
  assign word_s[1] = {ib.spi_dcx, ib.spi_outputs};
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic dc, input logic [7:0] d);
    @(negedge clk);
    ia.in_valid = v;
    ia.in_dc    = dc;
    ia.in_data  = d;
    #1;
    if (v && ia.in_ready) q0.push_back({dc, d});
    if (v && ib.in_ready) q1.push_back({dc, d});
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((ia.busy || ib.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(ia.busy || ib.busy), 0);
    @(negedge clk);
  endtask
  int lo_len [2] = '{0, 0};
  int gap [2] = '{0, 0};
  int run [2] = '{0, 0};
  int last_run [2] = '{0, 0};
  int npulse [2] = '{0, 0};
  logic [1:0] pw = 2'b11;
  logic [1:0] pc = 2'b11;
  logic [1:0] inburst = 2'b00;
  int rdx_bad = 0;
  logic [8:0] e;
  logic hd_ok;
  // bus monitor: strobe timing per instance and in-order scoreboard comparison at each latch edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!nRst) begin
        lo_len[i] = 0;
        gap[i] = 0;
        run[i] = 0;
        inburst[i] = 1'b0;
        pw[i] = 1'b1;
        pc[i] = 1'b1;
      end else begin
        gap[i]++;
        if (!rdx_s[i]) rdx_bad++;
        hd_ok = (i == 0) ? q0.size() != 0 : q1.size() != 0;
        if (pw[i] && !wrx_s[i]) begin
          if (inburst[i]) check($sformatf("period%0d", i), gap[i], 5);
          inburst[i] = 1'b1;
          gap[i] = 0;
          lo_len[i] = 0;
          if (hd_ok) check($sformatf("word_at_fall%0d", i), int'(word_s[i]), int'((i == 0) ? q0[0] : q1[0]));
        end
        if (!wrx_s[i]) lo_len[i]++;
        if (!pw[i] && wrx_s[i]) begin
          check($sformatf("wrx_low_len%0d", i), lo_len[i], WRL[i]);
          check($sformatf("csx_at_rise%0d", i), int'(csx_s[i]), 0);
          check($sformatf("sb_nonempty%0d", i), int'(hd_ok), 1);
          if (hd_ok) begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("word_at_rise%0d", i), int'(word_s[i]), int'(e));
          end
          npulse[i]++;
        end
        if (!csx_s[i]) run[i]++;
        else if (!pc[i]) begin
          last_run[i] = run[i];
          run[i] = 0;
          inburst[i] = 1'b0;
        end
        pw[i] = wrx_s[i];
        pc[i] = csx_s[i];
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, p1;
    logic saw_full;
    ia.in_valid = 1'b0;
    ia.in_dc    = 1'b0;
    ia.in_data  = 8'h00;
    #12;
    check("rst_data", int'(ia.spi_outputs), 8'h00);
    check("rst_dcx", int'(ia.spi_dcx), 1);
    check("rst_wrx", int'(ia.spi_wrx), 1);
    check("rst_rdx", int'(ia.spi_rdx), 1);
    check("rst_csx", int'(ia.spi_csx), 1);
    check("rst_ready", int'(ia.in_ready), 1);
    check("rst_busy", int'(ia.busy), 0);
    check("rst_count", int'(ia.fifo_count), 0);
    @(negedge clk);
    #2 nRst = 1'b1;
    drive(1'b1, 1'b0, 8'h2A);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
    check("single_csx_run", last_run[0], 5);
    check("single_pulses", npulse[0], 1);
    check("single_data_hold", int'({ia.spi_dcx, ia.spi_outputs}), 9'h02A);
    p0 = npulse[0];
    p1 = npulse[1];
    drive(1'b1, 1'b0, 8'h2C);
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b1, 8'h22);
    drive(1'b1, 1'b1, 8'h33);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
    check("burst_csx_run0", last_run[0], 20);
    check("burst_csx_run1", last_run[1], 20);
    check("burst_pulses0", npulse[0] - p0, 4);
    check("burst_pulses1", npulse[1] - p1, 4);
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b1, 8'hA2);
    drive(1'b1, 1'b1, 8'hA3);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("pre_pushpop_cnt", int'(ia.fifo_count), 2);
    drive(1'b1, 1'b1, 8'hA4);
    drive(1'b1, 1'b1, 8'hA5);
    check("pushpop_cnt", int'(ia.fifo_count), 2);
    drive(1'b1, 1'b1, 8'hA6);
    drive(1'b1, 1'b1, 8'hA7);
    check("full_cnt", int'(ia.fifo_count), 4);
    check("full_ready", int'(ia.in_ready), 0);
    drive(1'b1, 1'b1, 8'hA7);
    drive(1'b1, 1'b1, 8'hA7);
    drive(1'b0, 1'b0, 8'h00);
    check("refused_cnt", int'(ia.fifo_count), 3);
    check("refused_ready", int'(ia.in_ready), 1);
    wait_idle();
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i[0], 8'h40 + 8'(i));
      check("full_ready_rel", int'(ia.in_ready), int'(ia.fifo_count != 3'd4));
      if (ia.fifo_count == 3'd4) saw_full = 1'b1;
    end
    drive(1'b0, 1'b0, 8'h00);
    check("full_reached", int'(saw_full), 1);
    wait_idle();
    drive(1'b1, 1'b0, 8'hC1);
    drive(1'b1, 1'b1, 8'hC2);
    drive(1'b1, 1'b1, 8'hC3);
    drive(1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 20 && ia.spi_wrx; n++) @(negedge clk);
    check("mid_wrx_low", int'(ia.spi_wrx), 0);
    #2 nRst = 1'b0;
    #1;
    check("mid_rst_wrx", int'(ia.spi_wrx), 1);
    check("mid_rst_csx", int'(ia.spi_csx), 1);
    check("mid_rst_data", int'(ia.spi_outputs), 8'h00);
    check("mid_rst_dcx", int'(ia.spi_dcx), 1);
    check("mid_rst_busy", int'(ia.busy), 0);
    check("mid_rst_csx_b", int'(ib.spi_csx), 1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    #2 nRst = 1'b1;
    #1;
    check("post_rst_count", int'(ia.fifo_count), 0);
    check("post_rst_ready", int'(ia.in_ready), 1);
    drive(1'b1, 1'b1, 8'h5A);
    drive(1'b0, 1'b0, 8'h00);
    wait_idle();
    check("post_rst_run", last_run[0], 5);
    check("rdx_high", rdx_bad, 0);
    check("sb_drained0", q0.size(), 0);
    check("sb_drained1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/t08_lcd_bus_writer.md
# t08_lcd_bus_writer

Write engine for the display's 8080-style 8-bit parallel bus, placed directly downstream of the t08 display/graphics logic. It queues {D/C, byte} words in a small FIFO and drives each one out as a complete bus write cycle on `spi_outputs`, `spi_wrx`, `spi_rdx`, `spi_csx` and `spi_dcx`, with programmable strobe timing. It is write-only: `spi_rdx` is always held high.

## Interface
Parameters
- `DEPTH`, 4: number of FIFO entries; must be a power of two, at least 2.
- `WR_LOW`, 2: number of cycles `spi_wrx` is held low per write; at least 1.
- `WR_HIGH`, 2: number of cycles `spi_wrx` is held high after the rising edge, as hold/recovery; at least 1.

Ports
- `clk`  in  1  system clock.
- `nRst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream offers a word.
- `in_ready`  out  1  block can accept a word; equals FIFO not full.
- `in_dc`  in  1  0 = command byte, 1 = data byte.
- `in_data`  in  8  byte to write.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.
- `fifo_count`  out  $clog2(DEPTH)+1  number of FIFO entries occupied.
- `spi_outputs`  out  8  parallel bus data.
- `spi_wrx`  out  1  write strobe, active low; the panel latches on the rising edge.
- `spi_rdx`  out  1  read strobe; held at 1 at all times.
- `spi_csx`  out  1  chip select, active low.
- `spi_dcx`  out  1  D/C select.

## Operation
- A push occurs when `in_valid && in_ready` at a clock edge. `in_ready` depends only on the full flag. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Pop: the FSM removes the head entry when it enters SETUP. A push and a pop in the same cycle are both honoured, and `fifo_count` stays unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `fifo_count` saturates at neither end: overflow and underflow cannot happen by construction.
- FSM states are IDLE, SETUP, WR_LO and WR_HI. A down-counter sized for max(WR_LOW, WR_HIGH) times the phases.
  - IDLE: `spi_csx`=1, `spi_wrx`=1. If the FIFO is non-empty, pop and go to SETUP.
  - SETUP (1 cycle): `spi_csx`=0, `spi_wrx`=1. `spi_outputs` and `spi_dcx` take the popped word. Go to WR_LO.
  - WR_LO (WR_LOW cycles): `spi_wrx`=0, data and dcx held. Go to WR_HI.
  - WR_HI (WR_HIGH cycles): `spi_wrx`=1, data and dcx held. On the last cycle:
    - if the FIFO is non-empty, pop and go to SETUP with `spi_csx` kept at 0 (back-to-back burst);
    - otherwise go to IDLE.
- `spi_outputs` and `spi_dcx` hold their last values in IDLE. They change only on entry to SETUP.
- All bus outputs are registered. No combinational path runs from `in_*` to any `spi_*` output.

## Timing
- Reset values:
  - `spi_outputs`=8'h00, `spi_dcx`=1, `spi_wrx`=1, `spi_rdx`=1, `spi_csx`=1;
  - `in_ready`=1, `busy`=0, `fifo_count`=0;
  - FIFO empty, FSM in IDLE.
- Latency, for a word pushed at edge k into an empty FIFO with the FSM idle:
  - the FSM pops at edge k+1, and outputs show SETUP after edge k+1;
  - `spi_wrx` falls after edge k+2 and rises after edge k+2+WR_LOW;
  - the FSM returns to IDLE (`spi_csx`=1) after edge k+2+WR_LOW+WR_HIGH.
- Throughput: one byte per 1+WR_LOW+WR_HIGH cycles, which is 5 with the defaults. `spi_csx` stays low for the whole of a continuous burst.
- Reset asserted mid-write: all outputs return to their reset values immediately and asynchronously. `spi_wrx` goes high and `spi_csx` goes high. FIFO contents are discarded.
- `busy` is registered-state-derived. It falls in the same cycle the FSM enters IDLE with an empty FIFO.

## Test plan
- Reset check: assert `nRst`=0 mid-burst → all bus outputs take their reset values in the same cycle; after release, `fifo_count`=0 and `in_ready`=1.
- Single write: push dc=0, data=8'h2A → `spi_csx` low for 5 cycles; `spi_wrx` low for exactly 2 cycles; `spi_outputs`=8'h2A and `spi_dcx`=0 stable from SETUP until CSX rises.
- Burst: push 8'h2C (dc=0), then 8'h11, 8'h22, 8'h33 (dc=1) on consecutive cycles →
  - four WRX pulses, 5 cycles apart;
  - CSX low continuously for 20 cycles;
  - the byte/dc sequence is preserved in order.
- Full: with DEPTH=4, hold `in_valid`=1 for 10 cycles → `in_ready`=0 whenever `fifo_count`=4; no word is lost or duplicated; the output order matches the accepted order.
- Push and pop in the same cycle at `fifo_count`=2 → count stays 2; at `fifo_count`=4 the push is refused.
- Parameter sweep: WR_LOW=1, WR_HIGH=3 → WRX low for 1 cycle; period of 5 cycles; `spi_rdx`=1 throughout all tests.
